road_throttle: RTL and testbench

- Upstream speed controller for the road scroller.
- Converts player accelerate/brake buttons and collision events into:
  - the 8-bit scroll period `speed` consumed by the road stage;
  - a gated tick `road_en` that drives the road stage's `clk_en`.
- Implements a STOP/RUN/CRASH state machine with saturating accelerate, brake and coast ramps, and a post-crash lockout.
- Sits between the input debouncers / collision detector and the road stage, in the frame-tick domain.

---
 rtl/road_throttle.sv | 156 +++++++++++++++
 tb/tb_road_throttle.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/road_throttle.sv
// Speed controller: accel/brake/coast ramps on frame ticks, crash lockout, scene gating.
// Latency: speed/stopped/crashed registered (1 cycle); road_en combinational from clk_en.
// Backpressure: none; inputs are level/pulse sampled, outputs always valid.
module road_throttle #(
    parameter int         MIN_PERIOD  = 8,
    parameter int         MAX_PERIOD  = 255,
    parameter int         ACC_DIV     = 4,
    parameter int         ACC_STEP    = 2,
    parameter int         BRAKE_STEP  = 8,
    parameter int         COAST_DIV   = 16,
    parameter int         CRASH_TICKS = 120,
    parameter logic [1:0] PLAY_SCENE  = 2'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [1:0] scene,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       crash,
    output logic [7:0] speed,
    output logic       road_en,
    output logic       stopped,
    output logic       crashed
);

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_CRASH} state_t;
    typedef enum logic [1:0] {M_COAST, M_ACCEL, M_BRAKE} mode_t;

    localparam int DIV_MAX = (COAST_DIV > ACC_DIV) ? COAST_DIV : ACC_DIV;
    localparam int SW      = $clog2(DIV_MAX + 1);
    localparam int LW      = $clog2(CRASH_TICKS + 1);

    localparam logic [8:0] MIN9 = 9'(MIN_PERIOD);
    localparam logic [8:0] MAX9 = 9'(MAX_PERIOD);
    localparam logic [8:0] ACC9 = 9'(ACC_STEP);
    localparam logic [8:0] BRK9 = 9'(BRAKE_STEP);
    localparam logic [7:0] MIN8 = 8'(MIN_PERIOD);
    localparam logic [7:0] MAX8 = 8'(MAX_PERIOD);

    state_t          state_q, state_d;
    mode_t           mode, mode_q, mode_d;
    logic [7:0]      speed_d, step_val;
    logic [8:0]      sum;
    logic [SW-1:0]   step_q, step_d, div_last;
    logic [LW-1:0]   lock_q, lock_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOP;
            speed   <= MAX8;
            stopped <= 1'b1;
            crashed <= 1'b0;
            step_q  <= '0;
            lock_q  <= '0;
            mode_q  <= M_COAST;
        end else begin
            state_q <= state_d;
            speed   <= speed_d;
            stopped <= (state_d == ST_STOP);
            crashed <= (state_d == ST_CRASH);
            step_q  <= step_d;
            lock_q  <= lock_d;
            mode_q  <= mode_d;
        end
    end

    // Brake dominates when both buttons are held.
    always_comb begin
        if (btn_down)    mode = M_BRAKE;
        else if (btn_up) mode = M_ACCEL;
        else             mode = M_COAST;
    end

    // Saturating step candidate, 9-bit so the carry/borrow is visible.
    always_comb begin
        sum      = {1'b0, speed};
        step_val = speed;
        div_last = SW'(ACC_DIV - 1);
        case (mode)
            M_ACCEL: begin
                sum      = {1'b0, speed} - ACC9;
                step_val = (sum[8] || (sum < MIN9)) ? MIN8 : sum[7:0];
            end
            M_BRAKE: begin
                sum      = {1'b0, speed} + BRK9;
                step_val = (sum > MAX9) ? MAX8 : sum[7:0];
            end
            default: begin
                sum      = {1'b0, speed} + 9'd1;
                step_val = (sum > MAX9) ? MAX8 : sum[7:0];
                div_last = SW'(COAST_DIV - 1);
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        speed_d = speed;
        step_d  = step_q;
        lock_d  = lock_q;
        mode_d  = mode_q;
        if (scene != PLAY_SCENE) begin
            state_d = ST_STOP;
            speed_d = MAX8;
            step_d  = '0;
            lock_d  = '0;
            mode_d  = M_COAST;
        end else if (crash) begin
            state_d = ST_CRASH;
            speed_d = MAX8;
            step_d  = '0;
            lock_d  = LW'(CRASH_TICKS - 1);
        end else if (clk_en) begin
            case (state_q)
                ST_STOP: begin
                    if (mode == M_ACCEL) begin
                        state_d = ST_RUN;
                        speed_d = MAX8;
                        step_d  = '0;
                        mode_d  = M_ACCEL;
                    end
                end
                ST_RUN: begin
                    if (speed == MAX8 && mode != M_ACCEL) begin
                        state_d = ST_STOP;
                        step_d  = '0;
                        mode_d  = M_COAST;
                    end else if (mode != mode_q) begin
                        step_d = '0;
                        mode_d = mode;
                    end else if (step_q == div_last) begin
                        speed_d = step_val;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                ST_CRASH: begin
                    speed_d = MAX8;
                    if (lock_q == '0) begin
                        state_d = ST_STOP;
                        step_d  = '0;
                        mode_d  = M_COAST;
                    end else begin
                        lock_d = lock_q - 1'b1;
                    end
                end
                default: state_d = ST_STOP;
            endcase
        end
    end

    always_comb road_en = clk_en && (state_q == ST_RUN);

endmodule

// File: tb/tb_road_throttle.sv
// Scoreboarded bench for road_throttle: directed test-plan phases then random traffic,
// compared every cycle against a tick-counting reference model.
module tb_road_throttle;

    localparam int MINP = 8;
    localparam int MAXP = 255;
    localparam int CRASH_T = 120;

    logic       clk = 1'b0;
    logic       rst, clk_en, btn_up, btn_down, crash;
    logic [1:0] scene;
    logic [7:0] speed;
    logic       road_en, stopped, crashed;

    always #5 clk = ~clk;

    road_throttle dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .scene    (scene),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .crash    (crash),
        .speed    (speed),
        .road_en  (road_en),
        .stopped  (stopped),
        .crashed  (crashed)
    );

    typedef struct packed {
        logic [7:0] speed;
        logic       stopped;
        logic       crashed;
        logic       road_en;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: running flag, remaining crash ticks, ticks held in the current mode.
    bit m_valid = 0;
    bit m_run   = 0;
    int m_speed = MAXP;
    int m_crash_left = 0;
    int m_prev_mode = 0;
    int m_held = 0;

    function automatic obs_t model_obs();
        obs_t o;
        o.speed   = 8'(m_speed);
        o.stopped = !m_run && (m_crash_left == 0);
        o.crashed = (m_crash_left > 0);
        o.road_en = clk_en && m_run;
        return o;
    endfunction

    task automatic model_update();
        int md;
        int div;
        md = btn_down ? 2 : (btn_up ? 1 : 0);
        if (rst || scene != 2'd1) begin
            m_valid = 1; m_run = 0; m_speed = MAXP; m_crash_left = 0;
        end else if (crash) begin
            m_run = 0; m_speed = MAXP; m_crash_left = CRASH_T;
        end else if (clk_en) begin
            if (m_crash_left > 0) begin
                m_crash_left--;
            end else if (!m_run) begin
                if (md == 1) begin m_run = 1; m_prev_mode = 1; m_held = 0; end
            end else if (m_speed == MAXP && md != 1) begin
                m_run = 0;
            end else if (md != m_prev_mode) begin
                m_prev_mode = md; m_held = 0;
            end else begin
                m_held++;
                div = (md == 0) ? 16 : 4;
                if (m_held % div == 0) begin
                    if (md == 1)      m_speed = (m_speed - 2 < MINP) ? MINP : m_speed - 2;
                    else if (md == 2) m_speed = (m_speed + 8 > MAXP) ? MAXP : m_speed + 8;
                    else              m_speed = (m_speed + 1 > MAXP) ? MAXP : m_speed + 1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        obs_t e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {speed, stopped, crashed, road_en};
            n_checks++;
            if (g === e) n_pass++;
            else $display("FAIL scoreboard @%0t: got speed=%0d stopped=%0b crashed=%0b road_en=%0b, expected speed=%0d stopped=%0b crashed=%0b road_en=%0b",
                          $time, g.speed, g.stopped, g.crashed, g.road_en, e.speed, e.stopped, e.crashed, e.road_en);
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    task automatic cyc();
        if (m_valid) exp_q.push_back(model_obs());
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic run_ticks(input int n, input int period);
        for (int t = 0; t < n; t++) begin
            for (int c = 1; c < period; c++) begin
                clk_en = 1'b0;
                cyc();
            end
            clk_en = 1'b1;
            cyc();
        end
        clk_en = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; clk_en = 1'b0; scene = 2'd1;
        btn_up = 1'b1; btn_down = 1'b0; crash = 1'b0;
        cyc();
        cyc();
        chk("reset_speed", speed, 255);
        chk("reset_stopped", stopped, 1);
        chk("reset_crashed", crashed, 0);
        chk("reset_road_en", road_en, 0);
        rst = 1'b0;

        run_ticks(1, 1);
        chk("accel_run_after_1", stopped, 0);
        run_ticks(4, 1);
        chk("accel_speed_5", speed, 253);
        run_ticks(492, 1);
        chk("accel_speed_497", speed, 8);
        run_ticks(13, 1);
        chk("accel_hold_min", speed, 8);

        btn_down = 1'b1;
        run_ticks(1, 1);
        chk("brake_entry_no_step", speed, 8);
        run_ticks(4, 1);
        chk("brake_speed_5", speed, 16);
        n = 5;
        while (!stopped && n < 300) begin
            run_ticks(1, 1);
            n++;
        end
        chk("brake_stop_tick", n, 126);
        chk("brake_stop_speed", speed, 255);

        btn_down = 1'b0;
        run_ticks(309, 1);
        chk("reaccel_speed", speed, 101);
        btn_up = 1'b0;
        run_ticks(16, 3);
        chk("coast_16", speed, 101);
        run_ticks(1, 3);
        chk("coast_17", speed, 102);

        btn_up = 1'b1; clk_en = 1'b0; crash = 1'b1;
        cyc();
        crash = 1'b0;
        chk("crash_flag", crashed, 1);
        chk("crash_speed", speed, 255);
        clk_en = 1'b1; #1;
        chk("crash_road_en", road_en, 0);
        run_ticks(119, 3);
        chk("crash_119_flag", crashed, 1);
        chk("crash_119_speed", speed, 255);
        run_ticks(1, 3);
        chk("crash_120_stopped", stopped, 1);
        chk("crash_120_crashed", crashed, 0);
        run_ticks(1, 3);
        chk("crash_121_run", stopped, 0);
        clk_en = 1'b1; #1;
        chk("crash_121_road_en", road_en, 1);

        run_ticks(20, 1);
        chk("scene_pre_speed", speed, 245);
        scene = 2'd2;
        run_ticks(1, 1);
        chk("scene_exit_speed", speed, 255);
        chk("scene_exit_stopped", stopped, 1);
        run_ticks(10, 1);
        chk("scene_ignore_btn", stopped, 1);
        scene = 2'd1;
        run_ticks(1, 1);
        chk("scene_return_run", stopped, 0);

        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 199) == 0) scene = 2'($urandom_range(0, 3));
            else if (scene != 2'd1 && $urandom_range(0, 19) == 0) scene = 2'd1;
            clk_en = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 29) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, 49) == 0) btn_down = ~btn_down;
            crash = ($urandom_range(0, 399) == 0);
            cyc();
        end
        #10;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
